flit_eject_interface: RTL and testbench

Ejection-side network interface for the MD5 accelerator NoC. It receives 69-bit flits from the local router output port and checks that each flit is addressed to this node. It buffers the 64-bit payloads in a small FIFO, delivers them to the local consumer over a valid/ready handshake, and returns one credit to the router per freed buffer slot. It is the receiving counterpart of the injection interface that packs data, VC, destination, tail and valid bits into flits.

---
 rtl/flit_eject_interface_if.sv | 33 +++
 rtl/flit_eject_interface.sv | 154 +++++++++++++++
 tb/tb_flit_eject_interface.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/flit_eject_interface_if.sv
// Purpose: bundles the router-facing flit input and the consumer-facing payload handshake.
// Latency: none; wiring only.
// Backpressure: i_data_ready from the consumer; the router is throttled by o_credit pulses.
// Ports: i_flit/i_flit_valid (router -> NI), o_data/o_tail/o_data_valid/i_data_ready (NI <-> consumer),
//        o_credit (NI -> router), o_misroute/o_overflow/o_count (status).
interface flit_eject_interface_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [68:0]   i_flit;
  logic          i_flit_valid;
  logic [63:0]   o_data;
  logic          o_tail;
  logic          o_data_valid;
  logic          i_data_ready;
  logic          o_credit;
  logic          o_misroute;
  logic          o_overflow;
  logic [CW-1:0] o_count;

  // Environment side: drives flits and consumer ready, observes everything else.
  modport master (
    output i_flit, i_flit_valid, i_data_ready,
    input  o_data, o_tail, o_data_valid, o_credit, o_misroute, o_overflow, o_count
  );

  // Ejection interface side.
  modport slave (
    input  i_flit, i_flit_valid, i_data_ready,
    output o_data, o_tail, o_data_valid, o_credit, o_misroute, o_overflow, o_count
  );
endinterface

// File: rtl/flit_eject_interface.sv
// Purpose: ejection network interface; filters flits by destination, buffers payloads, returns credits.
// Latency: 1 cycle from flit arrival to o_data_valid; credit 1 cycle after the freeing event.
// Backpressure: consumer stalls via i_data_ready; router is flow-controlled by credits, excess flits dropped.
// Ports: Clk, Rst_n (async active-low), bus (flit_eject_interface_if.slave).

// Generic single-clock FIFO. Caller guarantees push only when not full (or popping) and pop only when
// non-empty. Head is read combinationally from registered storage.
module eject_fifo #(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge Clk) begin
    if (push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head_dat = mem[rd_ptr];
endmodule

module flit_eject_interface #(
  parameter int         DEPTH   = 4,
  parameter logic [1:0] NODE_ID = 2'b00
) (
  input logic                  Clk,
  input logic                  Rst_n,
  flit_eject_interface_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  // Holds at least 2*DEPTH; a flow-controlled router never has more than DEPTH credits owed.
  localparam int PW = $clog2(2 * DEPTH + 1);
  localparam logic [PW:0] ONE = (PW + 1)'(1);

  typedef struct packed {
    logic        vld;
    logic        tail;
    logic [1:0]  dest;
    logic        vc;
    logic [63:0] dat;
  } flit_t;

  typedef struct packed {
    logic        tail;
    logic [63:0] dat;
  } entry_t;

  flit_t         flit;
  entry_t        push_dat;
  entry_t        head_dat;
  logic [CW-1:0] count;
  logic          data_vld;
  logic          arrival;
  logic          misroute;
  logic          pop;
  logic          full;
  logic          accept;
  logic          drop;
  logic [PW-1:0] pend;
  logic [PW:0]   pend_sum;
  logic          credit_q;
  logic          misroute_q;
  logic          overflow_q;
  logic          unused_vc;

  assign flit      = flit_t'(bus.i_flit);
  // VC selects nothing on the ejection side and is not stored.
  assign unused_vc = flit.vc;

  assign arrival  = bus.i_flit_valid && flit.vld;
  assign misroute = arrival && (flit.dest != NODE_ID);
  assign data_vld = (count != '0);
  assign pop      = data_vld && bus.i_data_ready;
  assign full     = (count == CW'(DEPTH));
  // A same-cycle pop frees the slot, so a full FIFO still takes the flit.
  assign accept   = arrival && !misroute && (!full || pop);
  assign drop     = arrival && !misroute && full && !pop;

  assign push_dat.tail = flit.tail;
  assign push_dat.dat  = flit.dat;

  eject_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .push     (accept),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head_dat),
    .count    (count)
  );

  // A pop and a misroute discard can each free a credit in the same cycle; only one pulse
  // leaves per cycle, the rest waits in pend.
  always_comb begin
    pend_sum = {1'b0, pend} + (PW + 1)'(pop) + (PW + 1)'(misroute);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pend       <= '0;
      credit_q   <= 1'b0;
      misroute_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (pend_sum != '0) begin
        credit_q <= 1'b1;
        pend     <= PW'(pend_sum - ONE);
      end else begin
        credit_q <= 1'b0;
        pend     <= '0;
      end
      misroute_q <= misroute_q | misroute;
      overflow_q <= drop;
    end
  end

  assign bus.o_data_valid = data_vld;
  assign bus.o_data       = data_vld ? head_dat.dat : 64'd0;
  assign bus.o_tail       = data_vld & head_dat.tail;
  assign bus.o_count      = count;
  assign bus.o_credit     = credit_q;
  assign bus.o_misroute   = misroute_q;
  assign bus.o_overflow   = overflow_q;
endmodule

// File: tb/tb_flit_eject_interface.sv
// Purpose: self-checking bench for flit_eject_interface with directed scenarios and a randomized run.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: ready is driven in stalled and free-running phases.
module tb_flit_eject_interface;
  localparam int         DEPTH   = 4;
  localparam logic [1:0] NODE_ID = 2'b00;
  localparam int         CW      = $clog2(DEPTH + 1);

  logic Clk   = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  flit_eject_interface_if #(.DEPTH(DEPTH)) bus ();

  flit_eject_interface #(.DEPTH(DEPTH), .NODE_ID(NODE_ID)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: payload queue of {tail, data}, owed credits, expected pulses, sticky flag.
  logic [64:0] mq[$];
  int          pend;
  bit          exp_cred;
  bit          exp_ovf;
  bit          exp_mis;

  function automatic logic [68:0] mk(input logic tail, input logic [1:0] dest, input logic vc,
                                     input logic [63:0] d);
    return {1'b1, tail, dest, vc, d};
  endfunction

  task automatic model_reset();
    mq.delete();
    pend     = 0;
    exp_cred = 0;
    exp_ovf  = 0;
    exp_mis  = 0;
  endtask

  // Drive one cycle of inputs, advance the model by that edge, then land 1 unit after the edge.
  task automatic cycle(input logic fv, input logic [68:0] f, input logic rdy);
    int n;
    bit arr;
    bit mis;
    bit pp;
    bus.i_flit       = f;
    bus.i_flit_valid = fv;
    bus.i_data_ready = rdy;
    n   = mq.size();
    arr = fv && f[68];
    mis = arr && (f[66:65] != NODE_ID);
    pp  = (n > 0) && rdy;
    exp_ovf = 0;
    if (pp) void'(mq.pop_front());
    if (arr && !mis) begin
      if (n < DEPTH || pp) mq.push_back({f[67], f[63:0]});
      else exp_ovf = 1;
    end
    pend = pend + int'(pp) + int'(mis);
    if (pend > 0) begin
      exp_cred = 1;
      pend     = pend - 1;
    end else begin
      exp_cred = 0;
    end
    if (mis) exp_mis = 1;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 69'd0, 1'b1);
  endtask

  task automatic test_reset();
    bus.i_flit       = '0;
    bus.i_flit_valid = 1'b0;
    bus.i_data_ready = 1'b0;
    Rst_n            = 1'b0;
    #2;
    checks++; if (bus.o_data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.o_data_valid); end
    checks++; if (bus.o_data !== 64'd0) begin errors++; $display("FAIL reset_data got %h want 0", bus.o_data); end
    checks++; if (bus.o_count !== CW'(0)) begin errors++; $display("FAIL reset_count got %0d want 0", bus.o_count); end
    checks++; if ({bus.o_credit, bus.o_misroute, bus.o_overflow, bus.o_tail} !== 4'b0) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {bus.o_credit, bus.o_misroute, bus.o_overflow, bus.o_tail});
    end
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    model_reset();
    @(posedge Clk);
    #1;
    checks++; if (bus.o_count !== CW'(0) || bus.o_credit !== 1'b0) begin
      errors++; $display("FAIL reset_release got count %0d credit %b want 0 0", bus.o_count, bus.o_credit);
    end
  endtask

  task automatic test_single_flit();
    cycle(1'b1, mk(1'b1, NODE_ID, 1'b1, 64'hDEADBEEF01234567), 1'b1);
    checks++; if (bus.o_data_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", bus.o_data_valid); end
    checks++; if (bus.o_data !== 64'hDEADBEEF01234567) begin errors++; $display("FAIL single_data got %h want deadbeef01234567", bus.o_data); end
    checks++; if (bus.o_tail !== 1'b1) begin errors++; $display("FAIL single_tail got %b want 1", bus.o_tail); end
    checks++; if (bus.o_count !== CW'(1)) begin errors++; $display("FAIL single_count got %0d want 1", bus.o_count); end
    cycle(1'b0, 69'd0, 1'b1);
    checks++; if (bus.o_credit !== 1'b1 || bus.o_count !== CW'(0)) begin
      errors++; $display("FAIL single_pop got credit %b count %0d want 1 0", bus.o_credit, bus.o_count);
    end
    cycle(1'b0, 69'd0, 1'b1);
    checks++; if (bus.o_credit !== 1'b0) begin errors++; $display("FAIL single_credit_len got %b want 0", bus.o_credit); end
  endtask

  task automatic test_fill_overflow();
    int ovf  = 0;
    int cred = 0;
    idle(6);
    for (int d = 1; d <= 5; d++) begin
      cycle(1'b1, mk(1'b0, NODE_ID, 1'b0, 64'(d)), 1'b0);
      ovf  += int'(bus.o_overflow);
      cred += int'(bus.o_credit);
      if (d == 5) begin
        checks++; if (bus.o_overflow !== 1'b1) begin errors++; $display("FAIL fill_ovf_pulse got %b want 1", bus.o_overflow); end
      end
    end
    checks++; if (bus.o_count !== CW'(4)) begin errors++; $display("FAIL fill_count got %0d want 4", bus.o_count); end
    checks++; if (ovf != 1 || cred != 0) begin errors++; $display("FAIL fill_pulses got ovf %0d credit %0d want 1 0", ovf, cred); end
    for (int k = 1; k <= 4; k++) begin
      checks++; if (bus.o_data !== 64'(k)) begin errors++; $display("FAIL fill_order got %0d want %0d", bus.o_data, k); end
      cycle(1'b0, 69'd0, 1'b1);
      cred += int'(bus.o_credit);
    end
    cycle(1'b0, 69'd0, 1'b0);
    cred += int'(bus.o_credit);
    checks++; if (cred != 4 || bus.o_count !== CW'(0)) begin
      errors++; $display("FAIL fill_drain got credits %0d count %0d want 4 0", cred, bus.o_count);
    end
  endtask

  task automatic test_misroute();
    idle(6);
    cycle(1'b1, mk(1'b0, 2'b10, 1'b0, 64'hA5), 1'b0);
    checks++; if (bus.o_count !== CW'(0) || bus.o_data_valid !== 1'b0) begin
      errors++; $display("FAIL mis_enq got count %0d valid %b want 0 0", bus.o_count, bus.o_data_valid);
    end
    checks++; if (bus.o_misroute !== 1'b1 || bus.o_credit !== 1'b1) begin
      errors++; $display("FAIL mis_flag got misroute %b credit %b want 1 1", bus.o_misroute, bus.o_credit);
    end
    cycle(1'b0, 69'd0, 1'b0);
    checks++; if (bus.o_misroute !== 1'b1 || bus.o_credit !== 1'b0) begin
      errors++; $display("FAIL mis_hold got misroute %b credit %b want 1 0", bus.o_misroute, bus.o_credit);
    end
  endtask

  task automatic test_pop_misroute();
    idle(6);
    cycle(1'b1, mk(1'b0, NODE_ID, 1'b0, 64'h77), 1'b0);
    cycle(1'b1, mk(1'b0, 2'b01, 1'b0, 64'h55), 1'b1);
    checks++; if (bus.o_credit !== 1'b1 || bus.o_count !== CW'(0)) begin
      errors++; $display("FAIL popmis_first got credit %b count %0d want 1 0", bus.o_credit, bus.o_count);
    end
    cycle(1'b0, 69'd0, 1'b0);
    checks++; if (bus.o_credit !== 1'b1) begin errors++; $display("FAIL popmis_second got %b want 1", bus.o_credit); end
    cycle(1'b0, 69'd0, 1'b0);
    checks++; if (bus.o_credit !== 1'b0) begin errors++; $display("FAIL popmis_third got %b want 0", bus.o_credit); end
  endtask

  task automatic test_full_push_pop();
    logic [63:0] exp_ord [5];
    exp_ord = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd9};
    idle(6);
    for (int d = 1; d <= 4; d++) cycle(1'b1, mk(1'b0, NODE_ID, 1'b0, 64'(d)), 1'b0);
    checks++; if (bus.o_data !== exp_ord[0]) begin errors++; $display("FAIL full_head got %0d want 1", bus.o_data); end
    cycle(1'b1, mk(1'b1, NODE_ID, 1'b0, 64'd9), 1'b1);
    checks++; if (bus.o_overflow !== 1'b0 || bus.o_count !== CW'(4)) begin
      errors++; $display("FAIL full_pushpop got ovf %b count %0d want 0 4", bus.o_overflow, bus.o_count);
    end
    for (int j = 1; j < 5; j++) begin
      checks++; if (bus.o_data !== exp_ord[j]) begin errors++; $display("FAIL full_order got %0d want %0d", bus.o_data, exp_ord[j]); end
      cycle(1'b0, 69'd0, 1'b1);
    end
    checks++; if (bus.o_count !== CW'(0)) begin errors++; $display("FAIL full_empty got %0d want 0", bus.o_count); end
  endtask

  task automatic test_back_to_back();
    idle(6);
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, mk(1'(k), NODE_ID, 1'(k >> 1), 64'h100 + 64'(k)), 1'b1);
      checks++; if (bus.o_data !== 64'h100 + 64'(k) || bus.o_count !== CW'(1)) begin
        errors++; $display("FAIL b2b_stream got data %h count %0d want %h 1", bus.o_data, bus.o_count, 64'h100 + 64'(k));
      end
    end
    cycle(1'b0, 69'd0, 1'b1);
  endtask

  task automatic test_reset_mid();
    idle(6);
    for (int d = 1; d <= 4; d++) cycle(1'b1, mk(1'b0, NODE_ID, 1'b0, 64'(d)), 1'b0);
    cycle(1'b1, mk(1'b0, 2'b11, 1'b0, 64'hEE), 1'b1);
    checks++; if (bus.o_count !== CW'(3) || bus.o_credit !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre got count %0d credit %b want 3 1", bus.o_count, bus.o_credit);
    end
    bus.i_flit_valid = 1'b0;
    bus.i_data_ready = 1'b0;
    #3;
    Rst_n = 1'b0;
    #1;
    checks++; if (bus.o_count !== CW'(0) || bus.o_data_valid !== 1'b0 || bus.o_data !== 64'd0) begin
      errors++; $display("FAIL rstmid_fifo got count %0d valid %b data %h want 0 0 0", bus.o_count, bus.o_data_valid, bus.o_data);
    end
    checks++; if ({bus.o_credit, bus.o_misroute, bus.o_overflow, bus.o_tail} !== 4'b0) begin
      errors++; $display("FAIL rstmid_flags got %b want 0000", {bus.o_credit, bus.o_misroute, bus.o_overflow, bus.o_tail});
    end
    model_reset();
    @(posedge Clk);
    #2;
    Rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 69'd0, 1'b0);
      checks++; if (bus.o_credit !== 1'b0) begin errors++; $display("FAIL rstmid_residual got %b want 0", bus.o_credit); end
    end
    cycle(1'b1, mk(1'b1, NODE_ID, 1'b0, 64'hC0FFEE), 1'b0);
    checks++; if (bus.o_data !== 64'hC0FFEE || bus.o_tail !== 1'b1 || bus.o_count !== CW'(1)) begin
      errors++; $display("FAIL rstmid_new got data %h tail %b count %0d want c0ffee 1 1", bus.o_data, bus.o_tail, bus.o_count);
    end
    cycle(1'b0, 69'd0, 1'b1);
    checks++; if (bus.o_credit !== 1'b1 || bus.o_count !== CW'(0)) begin
      errors++; $display("FAIL rstmid_pop got credit %b count %0d want 1 0", bus.o_credit, bus.o_count);
    end
  endtask

  task automatic test_random();
    logic        fv;
    logic        rdy;
    logic [68:0] f;
    logic [63:0] d;
    logic [63:0] eh;
    logic        et;
    for (int i = 0; i < 600; i++) begin
      d  = {$urandom, $urandom};
      f  = mk(1'($urandom % 2), ($urandom % 8 == 0) ? 2'($urandom_range(1, 3)) : NODE_ID, 1'($urandom % 2), d);
      if ($urandom % 8 == 0) f[68] = 1'b0;
      fv  = ($urandom % 4) != 0;
      rdy = (i % 100 < 30) ? ($urandom % 8 == 0) : ($urandom % 4 != 0);
      cycle(fv, f, rdy);
      eh = (mq.size() > 0) ? mq[0][63:0] : 64'd0;
      et = (mq.size() > 0) ? mq[0][64] : 1'b0;
      checks++; if (bus.o_count !== CW'(mq.size())) begin errors++; $display("FAIL rnd_count cyc %0d got %0d want %0d", i, bus.o_count, mq.size()); end
      checks++; if (bus.o_data_valid !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_valid cyc %0d got %b want %b", i, bus.o_data_valid, mq.size() > 0); end
      checks++; if (bus.o_data !== eh) begin errors++; $display("FAIL rnd_data cyc %0d got %h want %h", i, bus.o_data, eh); end
      checks++; if (bus.o_tail !== et) begin errors++; $display("FAIL rnd_tail cyc %0d got %b want %b", i, bus.o_tail, et); end
      checks++; if (bus.o_credit !== exp_cred) begin errors++; $display("FAIL rnd_credit cyc %0d got %b want %b", i, bus.o_credit, exp_cred); end
      checks++; if (bus.o_overflow !== exp_ovf) begin errors++; $display("FAIL rnd_overflow cyc %0d got %b want %b", i, bus.o_overflow, exp_ovf); end
      checks++; if (bus.o_misroute !== exp_mis) begin errors++; $display("FAIL rnd_misroute cyc %0d got %b want %b", i, bus.o_misroute, exp_mis); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_flit();
    test_fill_overflow();
    test_misroute();
    test_pop_misroute();
    test_full_push_pop();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
